// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: synchronised rx, internal xOVERSAMPLE tick,
// mid-bit sampling, optional parity, ready/valid holding register with error flags.
module uart_rx_os #(
  parameter int CLK_DIV    = 651,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t         state, state_n;
  logic           rx_m, rx_s;
  logic [DW-1:0]  div_cnt;
  logic           tick;
  logic [OSW-1:0] os_cnt, os_cnt_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     shreg, shreg_n;
  logic           par_err_r, par_err_n;
  logic           done;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + 1'b1;
  end

  always_comb begin
    state_n   = state;
    os_cnt_n  = os_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_err_n = par_err_r;
    done      = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        os_cnt_n = '0;
        state_n  = START;
      end
      START: if (tick) begin
        if (os_cnt == OS_MID) begin
          os_cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            bit_cnt_n = '0;
            par_err_n = 1'b0;
            state_n   = DATA;
          end
        end else begin
          os_cnt_n = os_cnt + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (os_cnt == OS_LAST) begin
          os_cnt_n  = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = (PARITY != 0) ? PAR : STOP;
        end else begin
          os_cnt_n = os_cnt + 1'b1;
        end
      end
      PAR: if (tick) begin
        if (os_cnt == OS_LAST) begin
          os_cnt_n  = '0;
          // Odd parity expects the XOR of data and parity bit to be 1.
          par_err_n = (^{shreg, rx_s}) ^ (PARITY == 2);
          state_n   = STOP;
        end else begin
          os_cnt_n = os_cnt + 1'b1;
        end
      end
      STOP: if (tick) begin
        if (os_cnt == OS_LAST) begin
          os_cnt_n = '0;
          done     = 1'b1;
          state_n  = rx_s ? IDLE : BRK;
        end else begin
          os_cnt_n = os_cnt + 1'b1;
        end
      end
      BRK: if (rx_s) begin
        os_cnt_n = '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_err_r <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      par_err_r <= par_err_n;
    end
  end

  // A completing frame may reuse the slot being emptied in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          rx_valid   <= 1'b1;
          frame_err  <= !rx_s;
          parity_err <= par_err_r;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid   <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: the robust receive end of the team's 8N1 UART link, intended to replace the single-tick receiver path in the UART top level. Features:
- Synchronises the asynchronous `rx` line and generates its own ×OVERSAMPLE sample tick.
- Validates the start bit at mid-bit and samples every data/parity/stop bit at its centre.
- Delivers bytes through a ready/valid holding register, with framing, parity and overrun flags.

## Interface
- `CLK_DIV`, default 651: clk cycles per oversample tick (baud = f_clk / (CLK_DIV·OVERSAMPLE)); legal ≥ 2.
- `OVERSAMPLE`, default 16: sample ticks per bit; must be even and ≥ 8.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: synchronous reset, active-low.
- `rx` in 1: asynchronous serial line; idle high.
- `rx_data` out 8: received byte, LSB first on the wire; valid while `rx_valid`.
- `rx_valid` out 1: holding register full.
- `rx_ready` in 1: consumer accepts; transfer happens when `rx_valid && rx_ready`.
- `frame_err` out 1: stop bit sampled low for the byte in the holding register; qualified by `rx_valid`.
- `parity_err` out 1: parity mismatch for the held byte; qualified by `rx_valid`; always 0 when PARITY = 0.
- `overrun` out 1: one-cycle pulse when a frame completes while `rx_valid` is high.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Synchroniser**: two flops on `rx`, both reset to 1. The FSM sees only the output `rx_s`.
- **Tick generator**: free-running counter 0..CLK_DIV-1; `tick` is high for one cycle when count = CLK_DIV-1. Width is $clog2(CLK_DIV).
- **Sample counter**: `os_cnt` counts ticks, width $clog2(OVERSAMPLE). It is cleared on every state entry and on start detect.
- **IDLE**: when `rx_s` = 0, clear `os_cnt` and go to START.
- **START**: on the tick where `os_cnt` = OVERSAMPLE/2-1, sample `rx_s`.
  - If 0: clear `os_cnt`, `bit_cnt` = 0, go to DATA.
  - If 1: treat as a glitch; return to IDLE with no output.
- **DATA**: on each tick where `os_cnt` = OVERSAMPLE-1, shift `rx_s` into the MSB of an 8-bit shift register (LSB-first reconstruction) and increment `bit_cnt`.
  - After the 8th sample: go to PAR if PARITY ≠ 0, else STOP.
- **PAR**: after OVERSAMPLE ticks, sample the parity bit.
  - Error if XOR(data, parity bit) ≠ 0 for even parity, or ≠ 1 for odd parity.
- **STOP**: after OVERSAMPLE ticks, sample the stop bit and complete the frame:
  - If `rx_valid` = 0: load `rx_data`, `frame_err` = !`rx_s`, and `parity_err`; set `rx_valid`.
  - If `rx_valid` = 1: discard the frame, pulse `overrun`, leave the holding register unchanged.
  - Next state: IDLE if `rx_s` = 1, else BRK.
- **BRK**: wait for `rx_s` = 1, then go to IDLE. A line held low never re-triggers a frame.
- **Handshake**: `rx_valid` clears on the cycle after `rx_valid && rx_ready`. On a transfer, `frame_err` and `parity_err` also clear. If a frame completes in the same cycle as a transfer, the new byte loads, `rx_valid` stays 1, and there is no overrun.
- **Reset**:
  - Outputs: `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, `busy` = 0.
  - Internal: state IDLE, tick and sample counters 0.
  - Reset mid-frame abandons the frame; there is no partial output.

## Timing
- Synchroniser latency: 2 clk.
- Start detection is resolved to within one tick (CLK_DIV clk) of the falling edge, plus 2 clk.
- Data/parity/stop samples occur OVERSAMPLE/2 ticks after each bit's nominal start, ±1 tick.
- `rx_valid` rises on the clk edge after the stop-bit sample tick. `overrun` pulses on that same edge.
- Frame length: 1 + 8 + (PARITY ≠ 0) + 1 bit periods. The receiver is back in IDLE immediately after the stop sample, so back-to-back frames with no idle gap are received.
- Tolerated baud mismatch: ±3 % at OVERSAMPLE = 16.

## Test plan
Common setup: CLK_DIV = 4, OVERSAMPLE = 16 (64 clk per bit).
- **Basic byte**: PARITY = 0; drive 0xA5 in 8N1 with `rx_ready` = 1 → `rx_valid` pulses for 1 cycle with `rx_data` = 0xA5, `frame_err` = 0; `busy` falls after the stop sample.
- **Back-to-back with backpressure**: send 0x00, 0xFF, 0x3C with no gaps and `rx_ready` = 0 → holds 0x00; `overrun` pulses twice. Then raise `rx_ready` → 0x00 transfers and `rx_valid` drops.
- **Glitch and break**:
  - A 20-clk low glitch → no `rx_valid`, returns to IDLE.
  - 0x55 with stop bit low, line held low for 2000 clk → `rx_data` = 0x55, `frame_err` = 1, FSM stays in BRK until line high; no spurious frame.
- **Parity**: PARITY = 1, send 0x07 with parity bit 1 → `parity_err` = 0. Same byte with parity bit 0 → `parity_err` = 1. PARITY = 2 with parity bit 0 → `parity_err` = 0.
- **Baud skew**: send 0xC3 at 62 and 66 clk/bit → `rx_data` = 0xC3, no errors.
- **Reset**: assert `reset_n` = 0 mid-DATA of 0x81 → all outputs return to reset values on the next edge; the following clean 0x81 is received correctly.
